// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the RV32M multi-cycle multiply/divide sequencer:
//   - funct3 operation encodings (MUL..REMU)
//   - FSM state encoding (3 bits) and the state enum built on it
//   - cnt_width(): iteration counter width derived from the operand width
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PREP = 3'd1;
  localparam logic [2:0] ST_CALC = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    PREP = ST_PREP,
    CALC = ST_CALC,
    FIX  = ST_FIX,
    DONE = ST_DONE
  } state_t;

  // The counter counts WIDTH-1 down to 0, so log2(WIDTH) bits suffice.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/cond_negate.sv
// cond_negate
// Two's-complement negation of value when negate is set, pass-through
// otherwise. Used for operand magnitudes and for final sign correction.
// Ports:
//   value  in  WIDTH  operand
//   negate in  1      negate when high
//   result out WIDTH  value or -value (modulo 2^WIDTH)
module cond_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Multi-cycle RV32M multiply/divide unit: shift-add multiply and restoring
// divide, one iteration per cycle, with sign handling around the unsigned core.
// Ports:
//   clk         in  1      core clock
//   reset       in  1      synchronous active-high reset
//   start_i     in  1      request, accepted in IDLE or DONE
//   funct3_i    in  3      operation select (sampled with start_i)
//   rs1_data_i  in  WIDTH  multiplicand / dividend
//   rs2_data_i  in  WIDTH  multiplier / divisor
//   busy_o      out 1      high in PREP, CALC, FIX
//   done_o      out 1      one-cycle pulse in DONE
//   result_o    out WIDTH  registered result, held until next start or reset
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] rs1_data_i,
  input  logic [WIDTH-1:0] rs2_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t state, state_next;

  logic [2:0]         op;
  logic [WIDTH-1:0]   a_raw;
  logic [WIDTH-1:0]   b_raw;
  // Multiply: {high accumulator, multiplier shifting out}.
  // Divide: low half holds the quotient shifting in over the dividend.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem;
  // Multiplicand for multiply, divisor for divide.
  logic [WIDTH-1:0]   operand;
  logic               res_neg;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   result;

  logic               accept;
  logic               is_div;
  logic               is_rem;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               div_zero;
  logic               div_ovf;
  logic               special;
  logic [WIDTH-1:0]   special_val;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;

  logic [2*WIDTH-1:0] fix_in;
  logic [2*WIDTH-1:0] fix_out;
  logic [WIDTH-1:0]   fix_sel;

  assign accept = start_i && (state == IDLE || state == DONE);
  assign is_div = op[2];
  assign is_rem = op[2] & op[1];

  assign sign_a = a_raw[WIDTH-1] &&
                  (op == F3_MULH || op == F3_MULHSU || op == F3_DIV || op == F3_REM);
  assign sign_b = b_raw[WIDTH-1] &&
                  (op == F3_MULH || op == F3_DIV || op == F3_REM);

  cond_negate #(.WIDTH(WIDTH)) u_mag_a (
    .value  (a_raw),
    .negate (sign_a),
    .result (a_mag)
  );

  cond_negate #(.WIDTH(WIDTH)) u_mag_b (
    .value  (b_raw),
    .negate (sign_b),
    .result (b_mag)
  );

  // Divide corner cases bypass the iteration with RISC-V defined results.
  always_comb begin
    div_zero    = is_div && (b_raw == '0);
    div_ovf     = (op == F3_DIV || op == F3_REM) &&
                  (a_raw == {1'b1, {(WIDTH-1){1'b0}}}) && (b_raw == '1);
    special     = div_zero || div_ovf;
    special_val = '0;
    if (div_zero)
      special_val = is_rem ? a_raw : '1;
    else if (div_ovf)
      special_val = is_rem ? '0 : a_raw;
  end

  // One shift-add step: add the multiplicand into the high half when the
  // current multiplier bit is set, then shift the whole register right.
  always_comb begin
    mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    mul_next = prod[0] ? {mul_sum, prod[WIDTH-1:1]} : {1'b0, prod[2*WIDTH-1:1]};
  end

  // One restoring-divide step: shift in the next dividend bit and keep the
  // subtraction only if it did not borrow.
  always_comb begin
    div_shift = {rem, prod[WIDTH-1]};
    div_diff  = div_shift - {1'b0, operand};
  end

  // The product is negated at full width so the high half gets the correct
  // borrow; quotient and remainder are zero-extended into the same path.
  assign fix_in = is_div ? {{WIDTH{1'b0}}, (is_rem ? rem : prod[WIDTH-1:0])} : prod;

  cond_negate #(.WIDTH(2*WIDTH)) u_fix (
    .value  (fix_in),
    .negate (res_neg),
    .result (fix_out)
  );

  assign fix_sel = (op == F3_MUL || is_div) ? fix_out[WIDTH-1:0]
                                            : fix_out[2*WIDTH-1:WIDTH];

  // State register.
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_i) state_next = PREP;
      PREP: state_next = special ? DONE : CALC;
      CALC: if (cnt == '0) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = start_i ? PREP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath, counter and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      op      <= '0;
      a_raw   <= '0;
      b_raw   <= '0;
      prod    <= '0;
      rem     <= '0;
      operand <= '0;
      res_neg <= 1'b0;
      cnt     <= '0;
      result  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            op    <= funct3_i;
            a_raw <= rs1_data_i;
            b_raw <= rs2_data_i;
          end
        end
        PREP: begin
          res_neg <= is_rem ? sign_a : (sign_a ^ sign_b);
          cnt     <= CNT_W'(WIDTH - 1);
          if (special) begin
            result <= special_val;
          end else if (is_div) begin
            rem     <= '0;
            prod    <= {{WIDTH{1'b0}}, a_mag};
            operand <= b_mag;
          end else begin
            prod    <= {{WIDTH{1'b0}}, b_mag};
            operand <= a_mag;
          end
        end
        CALC: begin
          cnt <= cnt - CNT_W'(1);
          if (is_div) begin
            if (!div_diff[WIDTH]) begin
              rem  <= div_diff[WIDTH-1:0];
              prod <= {prod[2*WIDTH-1:WIDTH], prod[WIDTH-2:0], 1'b1};
            end else begin
              rem  <= div_shift[WIDTH-1:0];
              prod <= {prod[2*WIDTH-1:WIDTH], prod[WIDTH-2:0], 1'b0};
            end
          end else begin
            prod <= mul_next;
          end
        end
        FIX: result <= fix_sel;
        default: ;
      endcase
    end
  end

  assign busy_o   = (state == PREP) || (state == CALC) || (state == FIX);
  assign done_o   = (state == DONE);
  assign result_o = result;

endmodule
